// File: rtl/game_ctrl_param_pkg.sv
// Shared state codes and control-word decode for the memory game.
// The datapath and display decoder use the same state encoding.
package game_ctrl_param_pkg;

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_SETUP      = 3'd1,
      S_PLAY_FPGA  = 3'd2,
      S_PLAY_USER  = 3'd3,
      S_CHECK      = 3'd4,
      S_NEXT_ROUND = 3'd5,
      S_RETRY      = 3'd6,
      S_RESULT     = 3'd7
   } state_t;

   localparam int ROUNDS_DEF  = 16;
   localparam int TIMEOUT_DEF = 5000;
   localparam int LIVES_DEF   = 3;

   typedef struct packed {
      logic r1;
      logic r2;
      logic e1;
      logic e2;
      logic e3;
      logic e4;
      logic sel;
   } ctrl_t;

   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      unique case (s)
         S_INIT: begin
            c.r1 = 1'b1;
            c.r2 = 1'b1;
         end
         S_SETUP:      c.e1  = 1'b1;
         S_PLAY_FPGA:  c.e3  = 1'b1;
         S_PLAY_USER:  c.e2  = 1'b1;
         S_CHECK:      c.e4  = 1'b1;
         S_NEXT_ROUND: c.r2  = 1'b1;
         S_RETRY:      c.r2  = 1'b1;
         S_RESULT:     c.sel = 1'b1;
         default:      c     = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/game_ctrl_param_if.sv
// Controller <-> datapath bundle for the memory game.
// master = game controller, slave = datapath/display side.
interface game_ctrl_param_if #(
   parameter int RW = 5,
   parameter int LW = 2
);

   logic          enter;
   logic          end_FPGA;
   logic          key_valid;
   logic          end_User;
   logic          match;
   logic          R1;
   logic          R2;
   logic          E1;
   logic          E2;
   logic          E3;
   logic          E4;
   logic          SEL;
   logic [RW-1:0] round;
   logic [LW-1:0] lives;
   logic          win;
   logic          timeout;
   logic [2:0]    state_o;

   modport master (
      input  enter, end_FPGA, key_valid, end_User, match,
      output R1, R2, E1, E2, E3, E4, SEL,
      output round, lives, win, timeout, state_o
   );

   modport slave (
      output enter, end_FPGA, key_valid, end_User, match,
      input  R1, R2, E1, E2, E3, E4, SEL,
      input  round, lives, win, timeout, state_o
   );

endinterface

// File: rtl/game_timeout_timer.sv
// Per-keypress inactivity timer: counts while run, clears on clear,
// saturates at the last cycle and flags expiry there.
module game_timeout_timer #(
   parameter int TIMEOUT_CYC = 5000,
   parameter int TW          = $clog2(TIMEOUT_CYC)
) (
   input  logic CLOCK,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] cnt;

   always_ff @(posedge CLOCK) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!run || clear) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + TW'(1);
      end
   end

   // a key press on the last cycle still rescues the player
   assign expired = run && !clear && (cnt == LAST);

endmodule

// File: rtl/game_ctrl_param.sv
// Game control FSM with round counter, lives budget and input timeout.
// Control outputs are registered from the next state (Moore on state).
module game_ctrl_param #(
   parameter int ROUNDS      = 16,
   parameter int TIMEOUT_CYC = 5000,
   parameter int LIVES       = 3,
   parameter int RW          = $clog2(ROUNDS + 1),
   parameter int LW          = $clog2(LIVES + 1),
   parameter int TW          = $clog2(TIMEOUT_CYC)
) (
   input  logic              CLOCK,
   input  logic              reset,
   game_ctrl_param_if.master bus
);

   import game_ctrl_param_pkg::*;

   localparam logic [RW-1:0] RND_MAX = RW'(ROUNDS);
   localparam logic [RW-1:0] RND_1   = RW'(1);
   localparam logic [LW-1:0] LIV_MAX = LW'(LIVES);
   localparam logic [LW-1:0] LIV_1   = LW'(1);

   state_t        state;
   state_t        nxt;
   ctrl_t         ctrl_q;
   logic [RW-1:0] round_q;
   logic [LW-1:0] lives_q;
   logic          win_q;
   logic          timeout_q;
   logic          expired;
   logic          in_user;
   logic          last_round;
   logic          more_lives;
   logic          reload;

   assign in_user    = (state == S_PLAY_USER);
   assign last_round = (round_q == RND_MAX);
   assign more_lives = (lives_q > LIV_1);
   assign reload     = (state == S_INIT) ||
                       (state == S_RESULT && bus.enter);

   game_timeout_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TW          (TW)
   ) u_timer (
      .CLOCK   (CLOCK),
      .reset   (reset),
      .clear   (bus.key_valid),
      .run     (in_user),
      .expired (expired)
   );

   always_comb begin
      nxt = state;
      unique case (state)
         S_INIT:  nxt = S_SETUP;
         S_SETUP: if (bus.enter) nxt = S_PLAY_FPGA;
         S_PLAY_FPGA:
            if (bus.end_FPGA) nxt = S_PLAY_USER;
         S_PLAY_USER: begin
            // finishing input beats a simultaneous expiry
            if (bus.end_User)
               nxt = S_CHECK;
            else if (expired)
               nxt = more_lives ? S_RETRY : S_RESULT;
         end
         S_CHECK: begin
            if (bus.match)
               nxt = last_round ? S_RESULT : S_NEXT_ROUND;
            else
               nxt = more_lives ? S_RETRY : S_RESULT;
         end
         S_NEXT_ROUND: nxt = S_PLAY_FPGA;
         S_RETRY:      nxt = S_PLAY_FPGA;
         S_RESULT: if (bus.enter) nxt = S_INIT;
         default:  nxt = S_INIT;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!reset) begin
         state     <= S_INIT;
         ctrl_q    <= decode(S_INIT);
         round_q   <= RND_1;
         lives_q   <= LIV_MAX;
         win_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state  <= nxt;
         ctrl_q <= decode(nxt);
         if (reload) begin
            round_q   <= RND_1;
            lives_q   <= LIV_MAX;
            win_q     <= 1'b0;
            timeout_q <= 1'b0;
         end
         if (in_user && !bus.end_User && expired && !more_lives)
            timeout_q <= 1'b1;
         if (state == S_CHECK && bus.match && last_round)
            win_q <= 1'b1;
         if (state == S_NEXT_ROUND && !last_round)
            round_q <= round_q + RND_1;
         if (state == S_RETRY && more_lives)
            lives_q <= lives_q - LIV_1;
      end
   end

   assign bus.R1      = ctrl_q.r1;
   assign bus.R2      = ctrl_q.r2;
   assign bus.E1      = ctrl_q.e1;
   assign bus.E2      = ctrl_q.e2;
   assign bus.E3      = ctrl_q.e3;
   assign bus.E4      = ctrl_q.e4;
   assign bus.SEL     = ctrl_q.sel;
   assign bus.round   = round_q;
   assign bus.lives   = lives_q;
   assign bus.win     = win_q;
   assign bus.timeout = timeout_q;
   assign bus.state_o = state;

endmodule

// File: tb/tb_game_ctrl_param.sv
// Scoreboard bench: expected state records are queued by the driver,
// popped and compared by a monitor on every observed state change.
module tb_game_ctrl_param;

   import game_ctrl_param_pkg::*;

   localparam int ROUNDS      = 3;
   localparam int TIMEOUT_CYC = 8;
   localparam int LIVES       = 3;
   localparam int RW          = 2;
   localparam int LW          = 2;

   typedef struct {
      logic [2:0]    st;
      logic [RW-1:0] rnd;
      logic [LW-1:0] liv;
      logic          w;
      logic          to;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   exp_t q[$];
   logic [3:0] prev;

   game_ctrl_param_if #(.RW(RW), .LW(LW)) bus ();

   game_ctrl_param #(
      .ROUNDS      (ROUNDS),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .LIVES       (LIVES)
   ) dut (
      .CLOCK (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {R1,R2,E1,E2,E3,E4,SEL} expected in each state
   function automatic logic [6:0] ctl(input logic [2:0] s);
      case (s)
         3'd0:    return 7'b1100000;
         3'd1:    return 7'b0010000;
         3'd2:    return 7'b0000100;
         3'd3:    return 7'b0001000;
         3'd4:    return 7'b0000010;
         3'd5:    return 7'b0100000;
         3'd6:    return 7'b0100000;
         default: return 7'b0000001;
      endcase
   endfunction

   task automatic push(input state_t s, input int r, input int l,
                       input bit w, input bit t);
      exp_t e;
      e.st  = s;
      e.rnd = RW'(r);
      e.liv = LW'(l);
      e.w   = w;
      e.to  = t;
      q.push_back(e);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_st(input state_t s);
      int n;
      n = 0;
      while (bus.state_o !== s && n < 200) begin
         step();
         n++;
      end
      checks++;
      if (bus.state_o !== s) begin
         errors++;
         $display("FAIL wait_state got %0d want %0d", bus.state_o, s);
      end
   endtask

   task automatic pulse_enter();
      bus.enter = 1'b1;
      step();
      bus.enter = 1'b0;
   endtask

   task automatic fpga_only();
      wait_st(S_PLAY_FPGA);
      bus.end_FPGA = 1'b1;
      step();
      bus.end_FPGA = 1'b0;
      wait_st(S_PLAY_USER);
   endtask

   task automatic fpga_user();
      fpga_only();
      bus.end_User = 1'b1;
      step();
      bus.end_User = 1'b0;
   endtask

   // monitor
   initial begin
      exp_t e;
      logic [6:0] c;
      prev = 4'hF;
      forever begin
         @(negedge clk);
         if (!$isunknown(bus.state_o) && {1'b0, bus.state_o} != prev) begin
            prev = {1'b0, bus.state_o};
            checks++;
            c = {bus.R1, bus.R2, bus.E1, bus.E2, bus.E3, bus.E4, bus.SEL};
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_state got %0d with no entry queued",
                        bus.state_o);
            end else begin
               e = q.pop_front();
               if (bus.state_o !== e.st || bus.round !== e.rnd ||
                   bus.lives !== e.liv || bus.win !== e.w ||
                   bus.timeout !== e.to || c !== ctl(e.st)) begin
                  errors++;
                  $display("FAIL state_rec got st=%0d rnd=%0d liv=%0d win=%b to=%b ctl=%b want st=%0d rnd=%0d liv=%0d win=%b to=%b ctl=%b",
                           bus.state_o, bus.round, bus.lives, bus.win,
                           bus.timeout, c, e.st, e.rnd, e.liv, e.w, e.to,
                           ctl(e.st));
               end
            end
         end
      end
   end

   // driver
   initial begin
      int n;
      checks        = 0;
      errors        = 0;
      reset         = 1'b0;
      bus.enter     = 1'b0;
      bus.end_FPGA  = 1'b0;
      bus.key_valid = 1'b0;
      bus.end_User  = 1'b0;
      bus.match     = 1'b0;

      push(S_INIT, 1, 3, 0, 0);
      repeat (3) step();
      push(S_SETUP, 1, 3, 0, 0);
      reset = 1'b1;
      wait_st(S_SETUP);

      // game 1: three matched rounds -> win
      push(S_PLAY_FPGA, 1, 3, 0, 0);
      push(S_PLAY_USER, 1, 3, 0, 0);
      push(S_CHECK, 1, 3, 0, 0);
      push(S_NEXT_ROUND, 1, 3, 0, 0);
      push(S_PLAY_FPGA, 2, 3, 0, 0);
      push(S_PLAY_USER, 2, 3, 0, 0);
      push(S_CHECK, 2, 3, 0, 0);
      push(S_NEXT_ROUND, 2, 3, 0, 0);
      push(S_PLAY_FPGA, 3, 3, 0, 0);
      push(S_PLAY_USER, 3, 3, 0, 0);
      push(S_CHECK, 3, 3, 0, 0);
      push(S_RESULT, 3, 3, 1, 0);
      bus.match = 1'b1;
      pulse_enter();
      repeat (3) fpga_user();
      wait_st(S_RESULT);

      // restart from result clears win
      push(S_INIT, 1, 3, 0, 0);
      push(S_SETUP, 1, 3, 0, 0);
      pulse_enter();
      wait_st(S_SETUP);

      // game 2: two retries, end_User on expiry, reset mid round 3
      push(S_PLAY_FPGA, 1, 3, 0, 0);
      push(S_PLAY_USER, 1, 3, 0, 0);
      push(S_CHECK, 1, 3, 0, 0);
      push(S_RETRY, 1, 3, 0, 0);
      push(S_PLAY_FPGA, 1, 2, 0, 0);
      push(S_PLAY_USER, 1, 2, 0, 0);
      push(S_CHECK, 1, 2, 0, 0);
      push(S_RETRY, 1, 2, 0, 0);
      push(S_PLAY_FPGA, 1, 1, 0, 0);
      push(S_PLAY_USER, 1, 1, 0, 0);
      push(S_CHECK, 1, 1, 0, 0);
      push(S_NEXT_ROUND, 1, 1, 0, 0);
      push(S_PLAY_FPGA, 2, 1, 0, 0);
      push(S_PLAY_USER, 2, 1, 0, 0);
      push(S_CHECK, 2, 1, 0, 0);
      push(S_NEXT_ROUND, 2, 1, 0, 0);
      push(S_PLAY_FPGA, 3, 1, 0, 0);
      push(S_PLAY_USER, 3, 1, 0, 0);
      push(S_INIT, 1, 3, 0, 0);
      push(S_SETUP, 1, 3, 0, 0);
      bus.match = 1'b0;
      pulse_enter();
      fpga_user();
      wait_st(S_RETRY);
      fpga_user();
      wait_st(S_RETRY);
      bus.match = 1'b1;
      fpga_user();
      wait_st(S_NEXT_ROUND);
      fpga_only();
      repeat (TIMEOUT_CYC - 1) step();
      bus.end_User = 1'b1;
      step();
      bus.end_User = 1'b0;
      wait_st(S_NEXT_ROUND);
      fpga_only();
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();
      wait_st(S_INIT);
      reset = 1'b1;
      wait_st(S_SETUP);

      // game 3: keys keep timer alive, then three timeouts
      push(S_PLAY_FPGA, 1, 3, 0, 0);
      push(S_PLAY_USER, 1, 3, 0, 0);
      push(S_CHECK, 1, 3, 0, 0);
      push(S_NEXT_ROUND, 1, 3, 0, 0);
      push(S_PLAY_FPGA, 2, 3, 0, 0);
      push(S_PLAY_USER, 2, 3, 0, 0);
      push(S_RETRY, 2, 3, 0, 0);
      push(S_PLAY_FPGA, 2, 2, 0, 0);
      push(S_PLAY_USER, 2, 2, 0, 0);
      push(S_RETRY, 2, 2, 0, 0);
      push(S_PLAY_FPGA, 2, 1, 0, 0);
      push(S_PLAY_USER, 2, 1, 0, 0);
      push(S_RESULT, 2, 1, 0, 1);
      bus.match = 1'b1;
      pulse_enter();
      fpga_only();
      repeat (TIMEOUT_CYC - 1) step();
      bus.key_valid = 1'b1;
      step();
      for (int i = 0; i < 50; i++) begin
         bus.key_valid = (i % 6 == 5);
         step();
      end
      bus.key_valid = 1'b0;
      bus.end_User  = 1'b1;
      step();
      bus.end_User  = 1'b0;
      wait_st(S_NEXT_ROUND);
      repeat (3) begin
         fpga_only();
         n = 0;
         while (bus.state_o === S_PLAY_USER && n < 20) begin
            n++;
            step();
         end
         checks++;
         if (n != TIMEOUT_CYC) begin
            errors++;
            $display("FAIL user_cycles got %0d want %0d", n, TIMEOUT_CYC);
         end
      end
      wait_st(S_RESULT);

      push(S_INIT, 1, 3, 0, 0);
      push(S_SETUP, 1, 3, 0, 0);
      pulse_enter();
      wait_st(S_SETUP);

      n = 0;
      while (q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d left want 0", q.size());
      end
      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
